// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the serial transmit and receive ends.
package hamming_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit i of the result holds codeword position i+1: p1 p2 d1 p3 d2 d3 d4.
  function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] nib);
    logic p1;
    logic p2;
    logic p3;
    p1 = nib[0] ^ nib[1] ^ nib[3];
    p2 = nib[0] ^ nib[2] ^ nib[3];
    p3 = nib[1] ^ nib[2] ^ nib[3];
    return {nib[3], nib[2], nib[1], p3, nib[0], p2, p1};
  endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Combinational nibble-to-codeword Hamming(7,4) encoder.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] nibble,
  output logic [CW_W-1:0]   codeword
);

  assign codeword = hamming74_encode(nibble);

endmodule

// File: rtl/hamming74_serial_tx.sv
// Serial Hamming(7,4) transmitter: encodes a nibble and shifts it out as d_out/strobe_out.
// Optional HAMMING_ERR_INJECT_EN adds err_pos to flip one codeword position at accept.
module hamming74_serial_tx
  import hamming_pkg::*;
#(
  parameter int STROBE_HALF = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d_in,
  input  logic              start,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [2:0]        err_pos,
`endif
  output logic              d_out,
  output logic              strobe_out,
  output logic              busy,
  output logic              done
);

  localparam int                PH_W     = (STROBE_HALF > 1) ? $clog2(STROBE_HALF) : 1;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(STROBE_HALF - 1);
  localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);
  localparam logic [2:0]        BIT_LAST = 3'd6;

  logic [CW_W-1:0] cw_clean_s;
  logic [CW_W-1:0] cw_load_s;
  logic [CW_W-1:0] shift_nxt_s;

  state_e          state_q,  state_d;
  logic [PH_W-1:0] phase_q,  phase_d;
  logic [2:0]      bit_q,    bit_d;
  logic [CW_W-1:0] shift_q,  shift_d;
  logic            d_out_q,  d_out_d;
  logic            strobe_q, strobe_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;

  hamming74_enc u_enc (
    .nibble   (d_in),
    .codeword (cw_clean_s)
  );

`ifdef HAMMING_ERR_INJECT_EN
  logic [CW_W-1:0] err_mask_s;
  // Position 0 means "no injection"; positions 1..7 map to shift bits 0..6.
  always_comb begin
    if (err_pos != 3'd0) begin
      err_mask_s = 7'd1 << (err_pos - 3'd1);
    end else begin
      err_mask_s = 7'd0;
    end
  end
  assign cw_load_s = cw_clean_s ^ err_mask_s;
`else
  assign cw_load_s = cw_clean_s;
`endif

  assign shift_nxt_s = {1'b0, shift_q[CW_W-1:1]};

  // Next-state and next-output logic; outputs are registered alongside the state.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    d_out_d  = d_out_q;
    strobe_d = strobe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOW;
          shift_d  = cw_load_s;
          bit_d    = 3'd0;
          phase_d  = '0;
          d_out_d  = cw_load_s[0];
          strobe_d = 1'b0;
          busy_d   = 1'b1;
        end else begin
          d_out_d  = 1'b0;
          strobe_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      LOW: begin
        if (phase_q == PH_LAST) begin
          state_d  = HIGH;
          phase_d  = '0;
          strobe_d = 1'b1;
        end else begin
          phase_d  = phase_q + PH_ONE;
        end
      end
      HIGH: begin
        if (phase_q == PH_LAST) begin
          phase_d  = '0;
          strobe_d = 1'b0;
          shift_d  = shift_nxt_s;
          // d_out only moves here, at the start of LOW, never on a strobe edge.
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            d_out_d = 1'b0;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + 3'd1;
            d_out_d = shift_nxt_s[0];
          end
        end else begin
          phase_d  = phase_q + PH_ONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        d_out_d  = 1'b0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        phase_d  = '0;
        bit_d    = 3'd0;
        shift_d  = '0;
        d_out_d  = 1'b0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, counters, shift register and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= 3'd0;
      shift_q  <= '0;
      d_out_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      d_out_q  <= d_out_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign d_out      = d_out_q;
  assign strobe_out = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// Scoreboard bench for hamming74_serial_tx with a position-arithmetic Hamming reference model.
module tb_hamming74_serial_tx;

  localparam int SH        = 4;
  localparam int FRAME_CYC = 14 * SH + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] d_in = 4'd0;
  logic [2:0] err_pos = 3'd0;
  logic       d_out;
  logic       strobe_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [6:0] bits;
    logic [3:0] data;
    int         start_cyc;
  } exp_t;

  exp_t exp_q[$];

  hamming74_serial_tx #(.STROBE_HALF(SH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .start      (start),
`ifdef HAMMING_ERR_INJECT_EN
    .err_pos    (err_pos),
`endif
    .d_out      (d_out),
    .strobe_out (strobe_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Parity bit at position 2^k covers every other position whose index has bit k set.
  function automatic logic [6:0] model_encode(input logic [3:0] d, input int ep);
    logic [7:1] w;
    int dpos[4];
    dpos = '{3, 5, 6, 7};
    w = '0;
    for (int i = 0; i < 4; i++) w[dpos[i]] = d[i];
    for (int k = 0; k < 3; k++) begin
      int pp;
      pp = 1 << k;
      for (int j = 1; j <= 7; j++) begin
        if (j != pp && (j & pp) != 0) w[pp] = w[pp] ^ w[j];
      end
    end
    if (ep >= 1 && ep <= 7) w[ep] = ~w[ep];
    return w;
  endfunction

  // Syndrome is the XOR of the indices of all set positions; nonzero names the bad position.
  function automatic logic [3:0] model_decode(input logic [6:0] cw);
    logic [7:1] w;
    int s;
    w = cw;
    s = 0;
    for (int j = 1; j <= 7; j++) if (w[j]) s = s ^ j;
    if (s != 0) w[s] = ~w[s];
    return {w[7], w[6], w[5], w[3]};
  endfunction

  task automatic send(input logic [3:0] d, input logic [2:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    d_in    = d;
    err_pos = ep;
    start   = 1'b1;
    e.bits      = model_encode(d, int'(ep));
    e.data      = d;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start   = 1'b0;
    d_in    = 4'($urandom);
    err_pos = 3'd0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done not seen within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (d_out !== 1'b0 || strobe_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: d_out=%b strobe_out=%b busy=%b done=%b, required all 0",
               tag, d_out, strobe_out, busy, done);
    end
  endtask

  // Monitor: collects bits on strobe rising edges and scores each frame at its done pulse.
  initial begin : monitor
    int         nbits;
    logic [6:0] got;
    logic       prev_s;
    logic       held;
    exp_t       e;
    nbits = 0; got = '0; prev_s = 1'b0; held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nbits  = 0;
        got    = '0;
        prev_s = 1'b0;
      end else begin
        if (strobe_out && !prev_s) begin
          checks++;
          if (exp_q.size() == 0 || nbits >= 7) begin
            errors++;
            $display("FAIL unexpected_strobe: rise at cycle %0d, bits already %0d, pending frames %0d",
                     cyc, nbits, exp_q.size());
          end else begin
            if (nbits == 0) begin
              checks++;
              if (cyc != exp_q[0].start_cyc + SH + 1) begin
                errors++;
                $display("FAIL first_strobe: rise at cycle %0d, required %0d",
                         cyc, exp_q[0].start_cyc + SH + 1);
              end
            end
            got[nbits] = d_out;
            nbits++;
          end
          held = d_out;
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame: busy=%b at strobe rise, required 1", busy);
          end
        end else if (strobe_out && prev_s) begin
          checks++;
          if (d_out !== held) begin
            errors++;
            $display("FAIL d_out_stable: d_out=%b during strobe high, required %b", d_out, held);
          end
        end
        if (done) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done at cycle %0d with no frame pending", cyc);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (nbits != 7) begin
              errors++;
              $display("FAIL strobe_count: %0d strobes, required 7", nbits);
            end
            checks++;
            if (got !== e.bits) begin
              errors++;
              $display("FAIL frame_bits: got %b (pos7..pos1), required %b for d_in=%b",
                       got, e.bits, e.data);
            end
            checks++;
            if (cyc != e.start_cyc + FRAME_CYC) begin
              errors++;
              $display("FAIL done_cycle: done at cycle %0d, required %0d", cyc, e.start_cyc + FRAME_CYC);
            end
            checks++;
            if (busy !== 1'b0 || strobe_out !== 1'b0 || d_out !== 1'b0) begin
              errors++;
              $display("FAIL done_outputs: busy=%b strobe_out=%b d_out=%b, required 0 0 0",
                       busy, strobe_out, d_out);
            end
            checks++;
            if (model_decode(got) !== e.data) begin
              errors++;
              $display("FAIL loopback: decoded %b, required %b", model_decode(got), e.data);
            end
          end
          nbits = 0;
          got   = '0;
        end
        prev_s = strobe_out;
      end
    end
  end

  initial begin : stimulus
    logic [2:0] ep;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check_reset_outputs("idle_after_reset");

    // Directed frames, including data extremes.
    send(4'b1011, 3'd0); wait_done(FRAME_CYC + 10);
    send(4'b0000, 3'd0); wait_done(FRAME_CYC + 10);
    send(4'b1111, 3'd0); wait_done(FRAME_CYC + 10);

    // All nibbles, random gaps.
    for (int v = 0; v < 16; v++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ep = 3'd0;
`ifdef HAMMING_ERR_INJECT_EN
      ep = 3'($urandom_range(0, 7));
`endif
      send(4'(v), ep);
      wait_done(FRAME_CYC + 10);
    end

`ifdef HAMMING_ERR_INJECT_EN
    send(4'b1011, 3'd3); wait_done(FRAME_CYC + 10);
`endif

    // Start while busy is ignored.
    send(4'b1011, 3'd0);
    repeat (20) @(posedge clk);
    #1;
    d_in  = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(FRAME_CYC + 10);
    repeat (40) @(posedge clk);

    // Start during the DONE cycle is ignored.
    send(4'b0110, 3'd0);
    wait_done(FRAME_CYC + 10);
    d_in  = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);

    // Reset mid-frame, after the third strobe.
    send(4'b1011, 3'd0);
    repeat (24) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_frame_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_reset_outputs("after_abort_idle");
    send(4'b1011, 3'd0); wait_done(FRAME_CYC + 10);

    // Random traffic.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      ep = 3'd0;
`ifdef HAMMING_ERR_INJECT_EN
      ep = 3'($urandom_range(0, 7));
`endif
      send(4'($urandom), ep);
      wait_done(FRAME_CYC + 10);
    end

    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_frames: %0d frames never completed, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming74_serial_tx.md
Name: hamming74_serial_tx

Overview:
Transmit end of the serial Hamming(7,4) link; the receive end is the serial error-correcting decoder.
- Accepts a 4-bit nibble on a one-cycle start pulse.
- Encodes the nibble into a 7-bit Hamming codeword.
- Shifts the codeword out one bit per strobe, as d_out plus strobe_out, LSB position (p1) first.
- Sits between the switch/keypad input logic and the serial link.

Parameters:
- STROBE_HALF, 4: clock cycles per strobe phase (low phase, then high phase) for each bit; must be >= 1.
- CW_W, 7: codeword width; fixed, not overridable.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- d_in, input, 4: data nibble; d_in[0]=d1, d_in[1]=d2, d_in[2]=d3, d_in[3]=d4.
- start, input, 1: one-cycle request; d_in is sampled in the same cycle.
- d_out, output, 1: serial codeword bit.
- strobe_out, output, 1: high while d_out is valid; the receiver samples on the strobe rising edge.
- busy, output, 1: high from the cycle after start is accepted until the frame completes.
- done, output, 1: one-cycle pulse after the 7th strobe falls.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - d_out=0, strobe_out=0, busy=0, done=0.
  - FSM goes to IDLE; bit counter=0; phase counter=0; shift register=0.
- Encoding (applied at accept):
  - p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
  - Codeword positions 1..7 are p1 p2 d1 p3 d2 d3 d4, held in shift register bits [0..6].
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If start=1, register the codeword and go to LOW with bit counter=0.
  - busy=1 from the next cycle.
- LOW:
  - d_out = shift[0]; strobe_out=0.
  - Stay STROBE_HALF cycles, then go to HIGH.
- HIGH:
  - strobe_out=1; d_out is held stable for the whole phase.
  - After STROBE_HALF cycles: shift right and increment the bit counter.
  - If the bit counter was 6, go to DONE; otherwise go to LOW.
- DONE:
  - done=1 and busy=0 for exactly one cycle; strobe_out=0; d_out=0.
  - Then go to IDLE.
- Timing:
  - d_out changes only in the first cycle of LOW, so it is never changed on a strobe edge.
  - First strobe rising edge occurs STROBE_HALF+1 cycles after the start cycle.
  - done is asserted at cycle 14*STROBE_HALF+1 after start.
  - Exactly 7 strobe pulses per frame.
- Boundary conditions:
  - start while busy or in DONE: ignored; no queueing; d_in is not re-sampled.
  - start in the same cycle that DONE returns to IDLE: ignored; start is accepted only when the FSM is in IDLE.
  - Reset mid-frame: immediate abort; no done pulse; outputs return to their reset values.
  - Counter widths: phase counter is clog2(STROBE_HALF) bits, or 1 bit minimum; bit counter is 3 bits with no wrap beyond 6.

Optional Feature:
- Macro: HAMMING_ERR_INJECT_EN.
- With the macro defined:
  - Adds input err_pos[2:0].
  - At accept, if err_pos is nonzero, codeword position err_pos is inverted before shifting.
  - err_pos=0 means no error is injected.
  - Used to exercise receiver single-bit correction.
- Without the macro: the port is absent and the codeword is always clean.

Decomposition:
- Package hamming_pkg:
  - Constants CW_W=7 and DATA_W=4.
  - FSM state typedef (IDLE, LOW, HIGH, DONE).
  - Function hamming74_encode(nibble) returning the 7-bit codeword, shared with the decoder side.
- Sub-module hamming74_enc:
  - Pure combinational nibble-to-codeword encoder.
  - Instantiated by the transmitter; also reusable by the bench as the reference model.

Test Plan:
- Reset: hold rst_n=0, then release → d_out=0, strobe_out=0, busy=0, done=0; no strobes while start=0 for 100 cycles.
- d_in=4'b1011, start pulse, STROBE_HALF=4:
  - Bits sampled on strobe rising edges are 1,0,1,0,1,0,1.
  - Exactly 7 strobes; done pulses one cycle at start+57; busy then low.
- Data extremes: d_in=4'b0000 → 0,0,0,0,0,0,0; d_in=4'b1111 → 1,1,1,1,1,1,1.
- Loopback: all 16 nibbles through the serial decoder → decoder display equals d_in for every value.
- Start while busy: second start with d_in=4'b0001 mid-frame → frame still 1010101; no second frame begins.
- Reset mid-frame: rst_n=0 after the 3rd strobe → outputs drop immediately, no done pulse; a new start after release sends a full 7-bit frame.
- Error injection (HAMMING_ERR_INJECT_EN): d_in=4'b1011, err_pos=3 → bits 1,0,0,0,1,0,1; decoder corrects to 4'b1011.
